// File: rtl/mem_stage_sb.sv
// mem_stage_sb: pipeline MEM stage with load/store alignment, a Wishbone B4 classic
// single-access master and a posted-write store buffer of SB_DEPTH entries.
// Optional build macro MEM_BUS_TIMEOUT_EN adds a bus timeout counter (TIMEOUT cycles).
module mem_stage_sb #(
  parameter int unsigned SB_DEPTH = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] mem_alu_i,
  input  logic [31:0] mem_rsc2_i,
  input  logic [31:0] mem_pc_i,
  input  logic [31:0] mem_pc4_i,
  input  logic [4:0]  mem_rd_i,
  input  logic        mem_kill_i,
  input  logic        mem_is_mem_i,
  input  logic        mem_we_mem_i,
  input  logic [2:0]  mem_funct3_i,
  output logic [31:0] mem_pc_o,
  output logic [31:0] mem_pc4_o,
  output logic [31:0] mem_alu_o,
  output logic [4:0]  mem_rd_o,
  output logic [31:0] mem_out_o,
  output logic        mem_stall_o,
  output logic        mem_trap_o,
  output logic [1:0]  mem_cause_o,
  output logic        mem_store_err_o,
  output logic [31:0] mem_store_err_addr_o,
  input  logic [31:0] wbs_dat_i,
  input  logic        wbs_ack_i,
  input  logic        wbs_err_i,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic        wbs_we_o,
  output logic [31:0] wbs_addr_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  wbs_sel_o
);

  localparam int unsigned PtrW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(SB_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StResp} state_e;

  state_e          state_q;
  logic            cyc_q, stb_q, we_q;
  logic [31:0]     addr_q, dat_q, out_q, store_err_addr_q;
  logic [3:0]      sel_q;
  logic            store_err_q, resp_trap_q, killed_q;
  logic [2:0]      ld_f3_q;
  logic [1:0]      ld_a_q;

  logic [31:0]     sb_addr_q [SB_DEPTH];
  logic [31:0]     sb_dat_q  [SB_DEPTH];
  logic [3:0]      sb_sel_q  [SB_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic [1:0]  a;
  logic        f3_ok, misal, issue, dec_trap, load_req, store_req;
  logic        sb_full, sb_empty, enq, pop, busy, timeout, bus_resp, bus_err;
  logic [3:0]  sel_dec;
  logic [31:0] wdat_dec, shifted, ld_ext;

  assign mem_pc_o  = mem_pc_i;
  assign mem_pc4_o = mem_pc4_i;
  assign mem_alu_o = mem_alu_i;
  assign mem_rd_o  = mem_rd_i;

  assign a = mem_alu_i[1:0];

  // Decode access size into lane select, replicated write data and alignment check
  always_comb begin
    sel_dec  = 4'b1111;
    wdat_dec = mem_rsc2_i;
    misal    = 1'b0;
    case (mem_funct3_i[1:0])
      2'b00: begin
        sel_dec  = 4'b0001 << a;
        wdat_dec = {4{mem_rsc2_i[7:0]}};
      end
      2'b01: begin
        sel_dec  = 4'b0011 << a;
        wdat_dec = {2{mem_rsc2_i[15:0]}};
        misal    = a[0];
      end
      default: misal = (a != 2'b00);
    endcase
    if (mem_we_mem_i) f3_ok = (mem_funct3_i == 3'b000) || (mem_funct3_i == 3'b001) ||
                              (mem_funct3_i == 3'b010);
    else              f3_ok = (mem_funct3_i == 3'b000) || (mem_funct3_i == 3'b001) ||
                              (mem_funct3_i == 3'b010) || (mem_funct3_i == 3'b100) ||
                              (mem_funct3_i == 3'b101);
  end

  // In LOAD/RESP the instruction in the stage is the load already in flight
  assign issue     = mem_is_mem_i && !mem_kill_i && (state_q == StIdle || state_q == StDrain);
  assign dec_trap  = issue && (!f3_ok || misal);
  assign load_req  = issue && !mem_we_mem_i && f3_ok && !misal;
  assign store_req = issue && mem_we_mem_i && f3_ok && !misal;

  assign sb_full  = (count_q == CntW'(SB_DEPTH));
  assign sb_empty = (count_q == '0);
  assign enq      = store_req && !sb_full;
  assign busy     = (state_q == StLoad) || (state_q == StDrain);
  assign bus_resp = busy && (wbs_ack_i || wbs_err_i || timeout);
  assign bus_err  = wbs_err_i || timeout;
  assign pop      = (state_q == StDrain) && bus_resp;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT + 1);
  logic [ToW-1:0] to_cnt_q;

  assign timeout = busy && !wbs_ack_i && !wbs_err_i && (to_cnt_q == ToW'(TIMEOUT - 1));

  // Count silent cycles of the current bus access; restarts with every access
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                          to_cnt_q <= '0;
    else if (busy && !wbs_ack_i && !wbs_err_i && !timeout) to_cnt_q <= to_cnt_q + 1'b1;
    else                                                to_cnt_q <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  // Shift the addressed lane down, then sign- or zero-extend
  always_comb begin
    shifted = wbs_dat_i >> {ld_a_q, 3'b000};
    case (ld_f3_q)
      3'b000:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_ext = {24'h0, shifted[7:0]};
      3'b101:  ld_ext = {16'h0, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
  end

  // Stall: loads until the response, stores only while the buffer is full
  always_comb begin
    unique case (state_q)
      StIdle, StDrain: mem_stall_o = load_req || (store_req && sb_full);
      StLoad:          mem_stall_o = !mem_kill_i;
      default:         mem_stall_o = 1'b0;
    endcase
  end

  // Precise trap: decode faults immediately, bus faults in RESP
  always_comb begin
    mem_trap_o  = 1'b0;
    mem_cause_o = 2'b00;
    if (state_q == StResp) begin
      mem_trap_o  = resp_trap_q;
      mem_cause_o = resp_trap_q ? 2'b11 : 2'b00;
    end else if (dec_trap) begin
      mem_trap_o  = 1'b1;
      mem_cause_o = !f3_ok ? 2'b11 : (mem_we_mem_i ? 2'b10 : 2'b01);
    end
  end

  // Bus FSM with registered Wishbone and response outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cyc_q <= 1'b0; stb_q <= 1'b0; we_q <= 1'b0;
      addr_q <= '0; dat_q <= '0; sel_q <= '0;
      out_q <= '0; resp_trap_q <= 1'b0; killed_q <= 1'b0;
      store_err_q <= 1'b0; store_err_addr_q <= '0;
      ld_f3_q <= '0; ld_a_q <= '0;
    end else begin
      store_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load_req && sb_empty) begin
            state_q <= StLoad;
            cyc_q <= 1'b1; stb_q <= 1'b1; we_q <= 1'b0;
            addr_q <= {mem_alu_i[31:2], 2'b00}; dat_q <= '0; sel_q <= sel_dec;
            ld_f3_q <= mem_funct3_i; ld_a_q <= a; killed_q <= 1'b0;
          end else if (!sb_empty) begin
            state_q <= StDrain;
            cyc_q <= 1'b1; stb_q <= 1'b1; we_q <= 1'b1;
            addr_q <= {sb_addr_q[rd_ptr_q][31:2], 2'b00};
            dat_q <= sb_dat_q[rd_ptr_q]; sel_q <= sb_sel_q[rd_ptr_q];
          end
        end
        StLoad: begin
          if (bus_resp) begin
            cyc_q <= 1'b0; stb_q <= 1'b0; addr_q <= '0; sel_q <= '0;
            if (killed_q || mem_kill_i) begin
              state_q <= StIdle;
            end else begin
              state_q <= StResp;
              if (bus_err) resp_trap_q <= 1'b1;
              else         out_q <= ld_ext;
            end
          end else if (mem_kill_i) begin
            killed_q <= 1'b1;
          end
        end
        StDrain: begin
          if (bus_resp) begin
            state_q <= StIdle;
            cyc_q <= 1'b0; stb_q <= 1'b0; we_q <= 1'b0;
            addr_q <= '0; dat_q <= '0; sel_q <= '0;
            if (bus_err) begin
              store_err_q      <= 1'b1;
              store_err_addr_q <= sb_addr_q[rd_ptr_q];
            end
          end
        end
        StResp: begin
          state_q <= StIdle;
          out_q <= '0; resp_trap_q <= 1'b0;
        end
      endcase
    end
  end

  // Store buffer pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) wr_ptr_q <= (wr_ptr_q == PtrW'(SB_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= (rd_ptr_q == PtrW'(SB_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (enq && !pop)      count_q <= count_q + 1'b1;
      else if (!enq && pop) count_q <= count_q - 1'b1;
    end
  end

  // Store buffer storage; entries are only read when valid
  always_ff @(posedge clk_i) begin
    if (enq) begin
      sb_addr_q[wr_ptr_q] <= mem_alu_i;
      sb_dat_q[wr_ptr_q]  <= wdat_dec;
      sb_sel_q[wr_ptr_q]  <= sel_dec;
    end
  end

  assign wbs_cyc_o            = cyc_q;
  assign wbs_stb_o            = stb_q;
  assign wbs_we_o             = we_q;
  assign wbs_addr_o           = addr_q;
  assign wbs_dat_o            = dat_q;
  assign wbs_sel_o            = sel_q;
  assign mem_out_o            = out_q;
  assign mem_store_err_o      = store_err_q;
  assign mem_store_err_addr_o = store_err_addr_q;

endmodule

// File: tb/tb_mem_stage_sb.sv
// Directed testbench for mem_stage_sb (SB_DEPTH=2, TIMEOUT=4).
module tb_mem_stage_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu, rsc2, pc, pc4;
  logic [4:0]  rd;
  logic        kill, is_mem, we_mem;
  logic [2:0]  f3;
  logic [31:0] pc_o, pc4_o, alu_o, out;
  logic [4:0]  rd_o;
  logic        stall, trap, st_err;
  logic [1:0]  cause;
  logic [31:0] st_err_addr;
  logic [31:0] wb_rdat;
  logic        wb_ack, wb_err;
  logic        cyc, stb, wb_we;
  logic [31:0] wb_addr, wb_wdat;
  logic [3:0]  wb_sel;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage_sb #(.SB_DEPTH(2), .TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .mem_alu_i(alu), .mem_rsc2_i(rsc2), .mem_pc_i(pc), .mem_pc4_i(pc4), .mem_rd_i(rd),
    .mem_kill_i(kill), .mem_is_mem_i(is_mem), .mem_we_mem_i(we_mem), .mem_funct3_i(f3),
    .mem_pc_o(pc_o), .mem_pc4_o(pc4_o), .mem_alu_o(alu_o), .mem_rd_o(rd_o),
    .mem_out_o(out), .mem_stall_o(stall), .mem_trap_o(trap), .mem_cause_o(cause),
    .mem_store_err_o(st_err), .mem_store_err_addr_o(st_err_addr),
    .wbs_dat_i(wb_rdat), .wbs_ack_i(wb_ack), .wbs_err_i(wb_err),
    .wbs_cyc_o(cyc), .wbs_stb_o(stb), .wbs_we_o(wb_we),
    .wbs_addr_o(wb_addr), .wbs_dat_o(wb_wdat), .wbs_sel_o(wb_sel)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic m, input logic w, input logic [2:0] fn,
                    input logic [31:0] ad, input logic [31:0] d);
    is_mem = m; we_mem = w; f3 = fn; alu = ad; rsc2 = d;
  endtask

  // Load with zero-wait response; ack/err chosen by caller
  task automatic do_load(input string tag, input logic [2:0] fn, input logic [31:0] ad,
                         input logic [31:0] rdata, input logic ack, input logic err,
                         input logic [3:0] exp_sel, input logic [31:0] exp_out,
                         input logic exp_trap);
    logic [31:0] wa;
    wa = {ad[31:2], 2'b00};
    op(1'b1, 1'b0, fn, ad, 32'h0);
    #1 check({tag, " accept stall"}, stall, 1);
    tick();
    check({tag, " cyc"}, cyc, 1);
    check({tag, " we"}, wb_we, 0);
    check({tag, " sel"}, wb_sel, exp_sel);
    check({tag, " addr"}, wb_addr, wa);
    wb_ack = ack; wb_err = err; wb_rdat = rdata;
    #1 check({tag, " load stall"}, stall, 1);
    tick();
    wb_ack = 0; wb_err = 0;
    #1;
    check({tag, " resp stall"}, stall, 0);
    check({tag, " resp out"}, out, exp_out);
    check({tag, " resp trap"}, trap, exp_trap);
    check({tag, " resp cause"}, cause, exp_trap ? 32'd3 : 32'd0);
    check({tag, " resp cyc"}, cyc, 0);
    op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    check({tag, " out cleared"}, out, 0);
  endtask

  initial begin
    rst = 1; kill = 0; wb_ack = 0; wb_err = 0; wb_rdat = 0;
    pc = 32'h1000; pc4 = 32'h1004; rd = 5'd7;
    op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #2;
    check("rst cyc", cyc, 0);
    check("rst stb", stb, 0);
    check("rst sel", wb_sel, 0);
    check("rst addr", wb_addr, 0);
    check("rst dat", wb_wdat, 0);
    check("rst out", out, 0);
    check("rst stall", stall, 0);
    check("rst st_err", st_err, 0);
    check("pass pc4", pc4_o, 32'h1004);
    check("pass rd", rd_o, 7);
    @(negedge clk); rst = 0;
    tick();

    // Aligned word, byte signed/unsigned, error, ack+err together
    do_load("lw", 3'b010, 32'h100, 32'hDEADBEEF, 1, 0, 4'b1111, 32'hDEADBEEF, 0);
    do_load("lb", 3'b000, 32'h103, 32'h80123456, 1, 0, 4'b1000, 32'hFFFFFF80, 0);
    do_load("lbu", 3'b100, 32'h103, 32'h80123456, 1, 0, 4'b1000, 32'h00000080, 0);
    do_load("lhu", 3'b101, 32'h102, 32'h9ABC0000, 1, 0, 4'b1100, 32'h00009ABC, 0);
    do_load("lw err", 3'b010, 32'h104, 32'h12345678, 0, 1, 4'b1111, 32'h0, 1);
    do_load("ack+err", 3'b010, 32'h108, 32'h12345678, 1, 1, 4'b1111, 32'h0, 1);

    // Misaligned / reserved decodes trap immediately with no bus access
    op(1'b1, 1'b0, 3'b001, 32'h101, 32'h0);
    #1 check("lh mis trap", trap, 1);
    check("lh mis cause", cause, 1);
    check("lh mis stall", stall, 0);
    tick();
    check("lh mis cyc", cyc, 0);
    op(1'b1, 1'b1, 3'b010, 32'h102, 32'h0);
    #1 check("sw mis cause", cause, 2);
    tick();
    op(1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
    #1 check("f3 rsv trap", trap, 1);
    check("f3 rsv cause", cause, 3);
    tick();
    check("f3 rsv cyc", cyc, 0);
    op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();

    // SH then LW: load waits behind the drain
    op(1'b1, 1'b1, 3'b001, 32'h102, 32'h00001234);
    #1 check("sh stall", stall, 0);
    check("sh trap", trap, 0);
    tick();
    op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    #1 check("lw behind sb stall", stall, 1);
    check("lw behind sb cyc", cyc, 0);
    tick();
    check("sh drain we", wb_we, 1);
    check("sh drain sel", wb_sel, 4'b1100);
    check("sh drain dat", wb_wdat, 32'h12341234);
    check("sh drain addr", wb_addr, 32'h100);
    check("sh drain stall", stall, 1);
    wb_ack = 1;
    tick();
    wb_ack = 0;
    #1 check("lw after drain stall", stall, 1);
    check("lw after drain cyc", cyc, 0);
    tick();
    check("lw2 cyc", cyc, 1);
    check("lw2 we", wb_we, 0);
    wb_ack = 1; wb_rdat = 32'h11112222;
    tick();
    wb_ack = 0;
    #1 check("lw2 out", out, 32'h11112222);
    check("lw2 stall", stall, 0);
    op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();

    // Three SW with full buffer and slow slave
    op(1'b1, 1'b1, 3'b010, 32'h200, 32'hAAAA0001);
    #1 check("sw1 stall", stall, 0);
    tick();
    op(1'b1, 1'b1, 3'b010, 32'h204, 32'hBBBB0002);
    #1 check("sw2 stall", stall, 0);
    tick();
    op(1'b1, 1'b1, 3'b010, 32'h208, 32'hCCCC0003);
    check("sw1 bus addr", wb_addr, 32'h200);
    check("sw1 bus dat", wb_wdat, 32'hAAAA0001);
    for (int i = 0; i < 5; i++) begin
      #1 check("sw3 full stall", stall, 1);
      tick();
    end
    wb_ack = 1;
    #1 check("sw3 pop-cycle stall", stall, 1);
    tick();
    wb_ack = 0;
    #1 check("sw3 enq stall", stall, 0);
    check("between drains cyc", cyc, 0);
    tick();
    op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    check("sw2 bus addr", wb_addr, 32'h204);
    check("sw2 bus dat", wb_wdat, 32'hBBBB0002);
    wb_ack = 1;
    tick();
    wb_ack = 0;
    tick();
    check("sw3 bus addr", wb_addr, 32'h208);
    check("sw3 bus dat", wb_wdat, 32'hCCCC0003);
    wb_ack = 1;
    tick();
    wb_ack = 0;
    check("sb drained cyc", cyc, 0);
    tick();

    // Store bus error: imprecise pulse with latched address
    op(1'b1, 1'b1, 3'b010, 32'h300, 32'h55555555);
    tick();
    op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    check("sw err drain cyc", cyc, 1);
    wb_err = 1;
    tick();
    wb_err = 0;
    check("st_err pulse", st_err, 1);
    check("st_err addr", st_err_addr, 32'h300);
    check("st_err no trap", trap, 0);
    tick();
    check("st_err pulse end", st_err, 0);

    // Kill during LOAD: stall drops, bus completes, result discarded
    op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    tick();
    kill = 1;
    #1 check("kill stall", stall, 0);
    check("kill cyc held", cyc, 1);
    tick();
    check("kill cyc still", cyc, 1);
    wb_ack = 1; wb_rdat = 32'hFFFF0000;
    tick();
    wb_ack = 0;
    check("kill no trap", trap, 0);
    check("kill no out", out, 0);
    check("kill cyc done", cyc, 0);
    kill = 0;
    op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();

`ifdef MEM_BUS_TIMEOUT_EN
    // Silent slave: cyc held TIMEOUT cycles, then trap cause 11
    op(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("to cyc", cyc, 1);
      tick();
    end
    check("to cyc drop", cyc, 0);
    check("to trap", trap, 1);
    check("to cause", cause, 3);
    op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
`endif

    // Reset in the middle of a bus cycle drops cyc/stb at once
    op(1'b1, 1'b0, 3'b010, 32'h600, 32'h0);
    tick();
    check("pre-rst cyc", cyc, 1);
    #2 rst = 1;
    #1 check("async rst cyc", cyc, 0);
    check("async rst stb", stb, 0);
    op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk); rst = 0;
    tick();
    check("post-rst cyc", cyc, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
